mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Bus initiator for the 16-bit word-addressed data memory: drives MemRead/MemWrite/address/data_to_write and consumes readed_data.
- Copies a block of N words from a source region to a destination region, or fills a destination region with a constant.
- Sits beside the datapath as a memory-side helper; the CPU/testbench programs it and waits for done.

Parameters:
- ADDR_W, 16, address width (memory is 2^16 words)
- DATA_W, 16, word width

Ports:
- clock  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  command strobe, sampled on posedge, honoured only in IDLE
- mode  input  1  0 = copy, 1 = fill; latched with start
- src_addr  input  16  first source word address (copy only); latched with start
- dst_addr  input  16  first destination word address; latched with start
- length  input  16  word count N; latched with start
- fill_value  input  16  constant written in fill mode; latched with start
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  one-cycle pulse at command completion
- words_done  output  16  count of words written in the current or last command
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable (memory commits on posedge)
- address  output  16  memory word address
- data_to_write  output  16  write data
- readed_data  input  16  memory read data

Behaviour:
- Reset (sync, high): state = IDLE. busy, done, MemRead and MemWrite are 0. address, data_to_write and words_done are 0. Latched command registers are cleared.
- Reset mid-command: the FSM aborts at that posedge with no further writes. A write whose posedge coincides with reset is not issued (MemWrite is already forced 0 in that cycle's decode).
- States: IDLE, RD_ADDR, RD_CAPT, WR, FIN.
- IDLE: all enables 0, busy 0.
  - On start = 1: latch the command and clear words_done.
  - If length = 0, go to FIN.
  - Otherwise go to RD_ADDR (mode 0) or WR (mode 1).
- RD_ADDR: MemRead = 1, address = src pointer. Next state is RD_CAPT.
- RD_CAPT: MemRead = 1, address held at src pointer. readed_data is sampled into the word buffer at the posedge ending this state. Next state is WR.
  - The address is held for two cycles so that the memory's both-edge read is settled before capture.
- WR: MemWrite = 1, address = dst pointer, data_to_write = buffer (copy) or fill_value (fill). At the posedge ending WR:
  - words_done increments.
  - src and dst pointers each increment by 1, modulo 2^16; wrap from 0xFFFF to 0x0000 is legal and silent.
  - Remaining count decrements.
  - If the remaining count reaches 0, go to FIN; otherwise go to RD_ADDR (copy) or stay in WR (fill).
- FIN: done = 1 for exactly one cycle, busy = 0, enables 0. Next state is IDLE.
- MemRead and MemWrite are never high in the same cycle. Outside RD_ADDR/RD_CAPT/WR both are 0.
- address holds its last value when idle.
- Throughput: copy takes 3 cycles per word; fill takes 1 cycle per word.
- Start-to-done latency: copy = 3N + 2 cycles, fill = N + 2 cycles, N = 0 gives 2 cycles. Measured from the posedge sampling start to the posedge ending FIN.
- start while busy or in FIN is ignored; there is no queueing.
- Overlapping regions are processed strictly in ascending address order.
  - With dst > src and overlap, already-copied words propagate forward. This is defined behaviour, not an error.
- length = 0xFFFF is processed fully. words_done wraps naturally only if N = 0x10000, which is not representable.

Test Plan:
- Copy: preload mem[0x0010..0x0013] = 0xA001, 0xA002, 0xA003, 0xA004; start mode 0, src 0x0010, dst 0x0100, length 4 -> mem[0x0100..0x0103] equal those values; done pulses once, 14 cycles after start; words_done = 4.
- Fill: mode 1, dst 0x0200, length 3, fill_value 0xBEEF -> mem[0x0200..0x0202] = 0xBEEF; mem[0x0203] unchanged; done 5 cycles after start; MemRead never asserted.
- Wrap and zero length:
  - Copy src 0xFFFE, dst 0x0000, length 3 -> address sequence for reads is 0xFFFE, 0xFFFF, 0x0000 and dst advances 0x0000→0x0002; no X.
  - length 0 -> done 2 cycles after start with no MemRead or MemWrite.
- Start while busy: issue a second start (different dst) mid-copy -> it is ignored; only the first region is written; exactly one done.
- Reset mid-copy: assert reset during the WR of word 2 of 4 -> word 2 is not written; outputs are all 0 the cycle after; a fresh start then completes normally.
- Protocol check (assertion): MemRead & MemWrite never both 1. In every WR cycle, data_to_write equals the value read in the preceding RD_CAPT (copy mode).

Source files
------------

// File: rtl/mem_block_mover.sv
// Memory-side block mover: copies N words src->dst or fills dst with a constant, in ascending address order.
// Latency copy 3N+2 / fill N+2 cycles incl. start and FIN edges; no backpressure, start ignored unless IDLE.
module mem_block_mover #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [15:0]       length,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_done,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_to_write,
  input  logic [DATA_W-1:0] readed_data
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAPT, WR, FIN} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t              state;
  state_t              state_nxt;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [15:0]         remaining;
  logic [DATA_W-1:0]   fill_q;
  logic [DATA_W-1:0]   word_buf;
  logic [15:0]         words_done_q;
  logic [ADDR_W-1:0]   last_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      fill_q       <= '0;
      word_buf     <= '0;
      words_done_q <= '0;
      last_addr    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q       <= mode;
            src_ptr      <= src_addr;
            dst_ptr      <= dst_addr;
            remaining    <= length;
            fill_q       <= fill_value;
            words_done_q <= '0;
          end
        end
        RD_CAPT: word_buf <= readed_data;
        WR: begin
          // pointers wrap silently at the top of the address space
          src_ptr      <= src_ptr + ONE_A;
          dst_ptr      <= dst_ptr + ONE_A;
          remaining    <= remaining - 16'd1;
          words_done_q <= words_done_q + 16'd1;
        end
        default: ;
      endcase
      if (MemRead || MemWrite) last_addr <= address;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    address       = last_addr;
    data_to_write = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == 16'd0) state_nxt = FIN;
          else if (mode)       state_nxt = WR;
          else                 state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        busy      = 1'b1;
        MemRead   = 1'b1;
        address   = src_ptr;
        state_nxt = RD_CAPT;
      end
      RD_CAPT: begin
        // address held a second cycle so the read is settled before capture
        busy      = 1'b1;
        MemRead   = 1'b1;
        address   = src_ptr;
        state_nxt = WR;
      end
      WR: begin
        busy          = 1'b1;
        MemWrite      = 1'b1;
        address       = dst_ptr;
        data_to_write = mode_q ? fill_q : word_buf;
        if (remaining == 16'd1) state_nxt = FIN;
        else if (mode_q)        state_nxt = WR;
        else                    state_nxt = RD_ADDR;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a write coinciding with reset must never reach the memory
    if (reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory plus a sequential reference of each command.
module tb_mem_block_mover;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, mode;
  logic [15:0] src_addr, dst_addr, length, fill_value;
  logic        busy, done, MemRead, MemWrite;
  logic [15:0] words_done, address, data_to_write, readed_data;

  mem_block_mover #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .words_done(words_done),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .data_to_write(data_to_write), .readed_data(readed_data)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        init_req, pl_en;
  logic [15:0] pl_addr, pl_data;
  logic        cur_mode;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_log [$];
  logic [31:0] wr_log [$];
  int          done_cnt = 0;
  int          overlap_cnt = 0;
  int          wdata_bad = 0;
  logic [15:0] last_read = 16'h0;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h3C5A;
  endfunction

  assign readed_data = mem[address];

  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pattern(16'(i));
    end else if (MemWrite) begin
      mem[address] <= data_to_write;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  // bus monitor: logs every read/write cycle and tallies protocol violations
  always @(negedge clock) begin
    if (MemRead && MemWrite) overlap_cnt = overlap_cnt + 1;
    if (MemRead) begin
      rd_log.push_back(address);
      last_read = readed_data;
    end
    if (MemWrite) begin
      wr_log.push_back({address, data_to_write});
      if (!cur_mode && data_to_write !== last_read) wdata_bad = wdata_bad + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(posedge clock); #1;
    pl_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk($sformatf("%s.busy", name), busy, 0);
    chk($sformatf("%s.done", name), done, 0);
    chk($sformatf("%s.memread", name), MemRead, 0);
    chk($sformatf("%s.memwrite", name), MemWrite, 0);
    chk($sformatf("%s.address", name), address, 0);
    chk($sformatf("%s.wdata", name), data_to_write, 0);
    chk($sformatf("%s.words_done", name), words_done, 0);
  endtask

  task automatic run_cmd(input string name, input logic m, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] n,
                         input logic [15:0] f, input logic intrude);
    logic [15:0] exp_rd [$];
    logic [31:0] exp_wr [$];
    logic [15:0] a, v;
    int rb, wb, db, cnt, lat;
    logic busy_ok;
    // reference: words handled one at a time in ascending order
    for (int i = 0; i < int'(n); i++) begin
      a = d + 16'(i);
      v = m ? f : ref_mem[s + 16'(i)];
      if (!m) begin
        exp_rd.push_back(s + 16'(i));
        exp_rd.push_back(s + 16'(i));
      end
      ref_mem[a] = v;
      exp_wr.push_back({a, v});
    end
    lat = (n == 16'd0) ? 2 : (m ? int'(n) + 2 : 3 * int'(n) + 2);
    rb = rd_log.size(); wb = wr_log.size(); db = done_cnt;

    cur_mode = m; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; cnt = 1; busy_ok = 1'b1;
    while (!done && cnt < lat + 8) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (intrude && cnt == 4) begin
        start = 1'b1; dst_addr = d + 16'h0080;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cnt++;
    end
    start = 1'b0;
    chk($sformatf("%s.done_seen", name), done, 1);
    // count spans the start-sampling edge through the edge that ends FIN
    chk($sformatf("%s.latency", name), cnt + 1, lat);
    chk($sformatf("%s.words_done", name), words_done, n);
    chk($sformatf("%s.busy_during", name), busy_ok, 1);
    chk($sformatf("%s.busy_in_fin", name), busy, 0);
    @(posedge clock); #1;
    chk($sformatf("%s.done_one_cycle", name), done, 0);
    chk($sformatf("%s.done_count", name), done_cnt - db, 1);
    chk($sformatf("%s.rd_count", name), rd_log.size() - rb, exp_rd.size());
    for (int i = 0; i < exp_rd.size() && rb + i < rd_log.size(); i++)
      chk($sformatf("%s.rd_addr[%0d]", name, i), rd_log[rb + i], exp_rd[i]);
    chk($sformatf("%s.wr_count", name), wr_log.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && wb + i < wr_log.size(); i++)
      chk($sformatf("%s.wr_addr_data[%0d]", name, i), wr_log[wb + i], exp_wr[i]);
    chk($sformatf("%s.rd_wr_overlap", name), overlap_cnt, 0);
    chk($sformatf("%s.wdata_vs_read", name), wdata_bad, 0);
    for (int i = -2; i < int'(n) + 2; i++) begin
      a = d + 16'(i);
      chk($sformatf("%s.mem[%h]", name, a), mem[a], ref_mem[a]);
    end
    if (intrude) begin
      for (int i = 0; i < int'(n) + 2; i++) begin
        a = d + 16'h0080 + 16'(i);
        chk($sformatf("%s.untouched[%h]", name, a), mem[a], ref_mem[a]);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wcnt;
    logic [15:0] rs, rd, rn;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    init_req = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0; cur_mode = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pattern(16'(i));
    @(posedge clock); #1;
    init_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk_idle_outputs("reset");

    preload(16'h0010, 16'hA001);
    preload(16'h0011, 16'hA002);
    preload(16'h0012, 16'hA003);
    preload(16'h0013, 16'hA004);
    run_cmd("copy4", 1'b0, 16'h0010, 16'h0100, 16'd4, 16'h0, 1'b0);
    run_cmd("fill3", 1'b1, 16'h0000, 16'h0200, 16'd3, 16'hBEEF, 1'b0);
    run_cmd("wrap", 1'b0, 16'hFFFE, 16'h0000, 16'd3, 16'h0, 1'b0);
    run_cmd("zero_len", 1'b0, 16'h0010, 16'h0500, 16'd0, 16'h0, 1'b0);
    run_cmd("start_busy", 1'b0, 16'h0010, 16'h0300, 16'd4, 16'h0, 1'b1);

    // reset during the write of word 2 of a 4-word copy
    cur_mode = 1'b0; mode = 1'b0; src_addr = 16'h0010; dst_addr = 16'h0400;
    length = 16'd4; fill_value = 16'h0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (MemWrite) wcnt++;
      if (wcnt == 2) break;
      @(posedge clock); #1;
    end
    chk("rst.reached_wr2", wcnt, 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk_idle_outputs("rst_after");
    ref_mem[16'h0400] = ref_mem[16'h0010];
    chk("rst.word1_written", mem[16'h0400], ref_mem[16'h0400]);
    chk("rst.word2_not_written", mem[16'h0401], ref_mem[16'h0401]);
    chk("rst.word3_not_written", mem[16'h0402], ref_mem[16'h0402]);
    run_cmd("after_rst", 1'b0, 16'h0010, 16'h0400, 16'd4, 16'h0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rs = 16'h1000 + 16'($urandom_range(0, 15));
      rd = rs + 16'($urandom_range(0, 20)) - 16'd10;
      rn = 16'($urandom_range(0, 8));
      run_cmd($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), rs, rd, rn,
              16'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
